// File: rtl/algo_2ror1w_rdq.sv
// Two-lane read response queue in front of a 2ror1w memory: credit-gated request issue,
// in-order response FIFO per port. Optional same-cycle bypass: ALGO_2ROR1W_RDQ_BYPASS_EN.
module algo_2ror1w_rdq #(
  parameter int WIDTH    = 32,
  parameter int BITADDR  = 13,
  parameter int DEPTH    = 4,
  parameter int BITDEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mem_ready,
  input  logic [1:0]             cl_read,
  input  logic [2*BITADDR-1:0]   cl_rd_adr,
  output logic [1:0]             cl_rdy,
  output logic [1:0]             read,
  output logic [2*BITADDR-1:0]   rd_adr,
  input  logic [1:0]             rd_vld,
  input  logic [2*WIDTH-1:0]     rd_dout,
  output logic [1:0]             out_vld,
  output logic [2*WIDTH-1:0]     out_dout,
  input  logic [1:0]             out_rdy,
  output logic [1:0]             err
);

  localparam logic [BITDEPTH:0] FULL = (BITDEPTH+1)'(DEPTH);

  for (genvar p = 0; p < 2; p++) begin : g_lane
    logic [BITDEPTH:0]   crd_q, crd_d;
    logic [BITDEPTH:0]   infl_q, infl_d;
    logic [BITDEPTH:0]   cnt_q, cnt_d;
    logic [BITDEPTH-1:0] wr_ptr_q, rd_ptr_q;
    logic [WIDTH-1:0]    mem_q [DEPTH];
    logic                read_q;
    logic [BITADDR-1:0]  adr_q;
    logic                err_q;

    logic             accept, rsp_ok, spurious, full, empty;
    logic             pop, push, drop, bypass, crd_dec;
    logic [WIDTH-1:0] rsp_data;

    assign rsp_data = rd_dout[p*WIDTH +: WIDTH];
    assign full     = (cnt_q == FULL);
    assign empty    = (cnt_q == '0);

    assign cl_rdy[p] = ~rst & mem_ready & (crd_q < FULL);
    assign accept    = cl_read[p] & cl_rdy[p];

    // A response only counts if a request is actually outstanding on this lane.
    assign spurious = rd_vld[p] & (infl_q == '0);
    assign rsp_ok   = rd_vld[p] & (infl_q != '0);

`ifdef ALGO_2ROR1W_RDQ_BYPASS_EN
    assign bypass = rsp_ok & empty & out_rdy[p];
`else
    assign bypass = 1'b0;
`endif

    assign pop     = ~empty & out_rdy[p];
    assign push    = rsp_ok & ~bypass & (~full | pop);
    assign drop    = spurious | (rsp_ok & ~bypass & full & ~pop);
    assign crd_dec = pop | bypass;

    assign out_vld[p]                 = ~empty | bypass;
    assign out_dout[p*WIDTH +: WIDTH] = bypass ? rsp_data : mem_q[rd_ptr_q];
    assign read[p]                    = read_q;
    assign rd_adr[p*BITADDR +: BITADDR] = adr_q;
    assign err[p]                     = err_q;

    // NOTE: every variable gets a default first so these blocks stay purely combinational.
    always_comb begin
      crd_d = crd_q;
      if (accept && !crd_dec)      crd_d = crd_q + 1'b1;
      else if (!accept && crd_dec) crd_d = crd_q - 1'b1;

      infl_d = infl_q;
      if (read_q && !rsp_ok)       infl_d = infl_q + 1'b1;
      else if (!read_q && rsp_ok)  infl_d = infl_q - 1'b1;

      cnt_d = cnt_q;
      if (push && !pop)            cnt_d = cnt_q + 1'b1;
      else if (!push && pop)       cnt_d = cnt_q - 1'b1;
    end

    // NOTE: state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
      if (rst) begin
        crd_q    <= '0;
        infl_q   <= '0;
        cnt_q    <= '0;
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        read_q   <= 1'b0;
        adr_q    <= '0;
        err_q    <= 1'b0;
      end else begin
        crd_q  <= crd_d;
        infl_q <= infl_d;
        cnt_q  <= cnt_d;
        read_q <= accept;
        if (accept) adr_q    <= cl_rd_adr[p*BITADDR +: BITADDR];
        if (push)   wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)    rd_ptr_q <= rd_ptr_q + 1'b1;
        if (drop)   err_q    <= 1'b1;
      end
    end

    // NOTE: storage is not reset; occupancy and pointers alone decide what is valid.
    always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= rsp_data;
    end
  end

endmodule

// File: tb/tb_algo_2ror1w_rdq.sv
// Self-checking bench for algo_2ror1w_rdq: bench acts as fixed-latency memory and
// checks issue, credits and response order against a queue-based reference model.
module tb_algo_2ror1w_rdq;
  localparam int WIDTH    = 32;
  localparam int BITADDR  = 13;
  localparam int DEPTH    = 4;
  localparam int BITDEPTH = 2;
`ifdef ALGO_2ROR1W_RDQ_BYPASS_EN
  localparam int LAT_EXP = 2;
`else
  localparam int LAT_EXP = 3;
`endif

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 mem_ready;
  logic [1:0]           cl_read;
  logic [2*BITADDR-1:0] cl_rd_adr;
  logic [1:0]           cl_rdy;
  logic [1:0]           read;
  logic [2*BITADDR-1:0] rd_adr;
  logic [1:0]           rd_vld;
  logic [2*WIDTH-1:0]   rd_dout;
  logic [1:0]           out_vld;
  logic [2*WIDTH-1:0]   out_dout;
  logic [1:0]           out_rdy;
  logic [1:0]           err;

  algo_2ror1w_rdq #(.WIDTH(WIDTH), .BITADDR(BITADDR), .DEPTH(DEPTH), .BITDEPTH(BITDEPTH)) dut (
    .clk(clk), .rst(rst), .mem_ready(mem_ready), .cl_read(cl_read), .cl_rd_adr(cl_rd_adr),
    .cl_rdy(cl_rdy), .read(read), .rd_adr(rd_adr), .rd_vld(rd_vld), .rd_dout(rd_dout),
    .out_vld(out_vld), .out_dout(out_dout), .out_rdy(out_rdy), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int cyc    = 0;

  // Reference model: expected data per port in accept order; memory model pending reads.
  logic [WIDTH-1:0]   exp_q    [2][$];
  logic [BITADDR-1:0] pend_adr [2][$];
  int                 pend_due [2][$];
  logic [1:0]         exp_read = '0;
  logic [BITADDR-1:0] exp_adr  [2];
  int                 lat      [2];
  bit                 auto_mem = 1'b1;
  logic [1:0]         inj_vld  = '0;
  logic [WIDTH-1:0]   inj_data = '0;
  int                 n_acc    [2];
  int                 n_pop    [2];

  // Values sampled during the most recent tick.
  logic [1:0]         s_cl_rdy, s_out_vld, s_read, s_err, s_acc, s_pop;
  logic [2*BITADDR-1:0] s_rd_adr;

  function automatic logic [WIDTH-1:0] mem_data(int p, logic [BITADDR-1:0] a);
    return {(p == 1) ? 8'hB1 : 8'hA0, 11'h0, a};
  endfunction

  // One clock cycle: caller sets inputs just after a falling edge, then calls tick().
  task automatic tick();
    for (int p = 0; p < 2; p++) begin
      rd_vld[p] = inj_vld[p];
      rd_dout[p*WIDTH +: WIDTH] = inj_vld[p] ? inj_data : '0;
      if (auto_mem && pend_due[p].size() > 0 && pend_due[p][0] == cyc) begin
        rd_vld[p] = 1'b1;
        rd_dout[p*WIDTH +: WIDTH] = mem_data(p, pend_adr[p].pop_front());
        void'(pend_due[p].pop_front());
      end
    end
    #1;
    s_cl_rdy = cl_rdy; s_out_vld = out_vld; s_read = read; s_err = err; s_rd_adr = rd_adr;
    for (int p = 0; p < 2; p++) begin
      logic exp_rdy;
      exp_rdy = !rst && mem_ready && (exp_q[p].size() < DEPTH);
      checks++;
      if (cl_rdy[p] !== exp_rdy)
        $display("FAIL cl_rdy[%0d] cyc %0d: got %b want %b", p, cyc, cl_rdy[p], exp_rdy);
      else passed++;
      checks++;
      if (read[p] !== exp_read[p])
        $display("FAIL read[%0d] cyc %0d: got %b want %b", p, cyc, read[p], exp_read[p]);
      else passed++;
      if (exp_read[p]) begin
        checks++;
        if (rd_adr[p*BITADDR +: BITADDR] !== exp_adr[p])
          $display("FAIL rd_adr[%0d] cyc %0d: got %h want %h", p, cyc,
                   rd_adr[p*BITADDR +: BITADDR], exp_adr[p]);
        else passed++;
      end
      s_pop[p] = 1'b0;
      if (out_vld[p] && out_rdy[p]) begin
        s_pop[p] = 1'b1;
        n_pop[p]++;
        checks++;
        if (exp_q[p].size() == 0)
          $display("FAIL out_unexpected[%0d] cyc %0d: got data %h want no output", p, cyc,
                   out_dout[p*WIDTH +: WIDTH]);
        else if (out_dout[p*WIDTH +: WIDTH] !== exp_q[p][0])
          $display("FAIL out_dout[%0d] cyc %0d: got %h want %h", p, cyc,
                   out_dout[p*WIDTH +: WIDTH], exp_q[p][0]);
        else passed++;
        if (exp_q[p].size() > 0) void'(exp_q[p].pop_front());
      end
      if (auto_mem && read[p]) begin
        pend_adr[p].push_back(rd_adr[p*BITADDR +: BITADDR]);
        pend_due[p].push_back(cyc + lat[p]);
      end
      s_acc[p]    = cl_read[p] && cl_rdy[p];
      exp_read[p] = s_acc[p];
      if (s_acc[p]) begin
        n_acc[p]++;
        exp_adr[p] = cl_rd_adr[p*BITADDR +: BITADDR];
        exp_q[p].push_back(mem_data(p, cl_rd_adr[p*BITADDR +: BITADDR]));
      end
    end
    if (rst) begin
      for (int p = 0; p < 2; p++) begin
        exp_q[p].delete(); pend_adr[p].delete(); pend_due[p].delete();
      end
      exp_read = '0;
    end
    @(negedge clk);
    cyc++;
    inj_vld = '0;
  endtask

  task automatic drain(string name);
    int n = 0;
    cl_read = '0; out_rdy = 2'b11; mem_ready = 1'b1;
    while ((exp_q[0].size() > 0 || exp_q[1].size() > 0 || pend_due[0].size() > 0 ||
            pend_due[1].size() > 0 || exp_read != 2'b00) && n < 60) begin
      tick(); n++;
    end
    checks++;
    if (n >= 60) $display("FAIL %s_drain: got timeout after %0d cycles want empty", name, n);
    else passed++;
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_ready = 1'b1; cl_read = 2'b11; cl_rd_adr = '1; out_rdy = 2'b11;
    tick(); tick();
    checks++;
    if ({s_cl_rdy, s_read, s_out_vld, s_err} !== 8'h00)
      $display("FAIL reset_outputs: got rdy=%b read=%b vld=%b err=%b want all 0",
               s_cl_rdy, s_read, s_out_vld, s_err);
    else passed++;
    checks++;
    if (s_rd_adr !== '0) $display("FAIL reset_rd_adr: got %h want 0", s_rd_adr);
    else passed++;
    rst = 1'b0; cl_read = 2'b01; cl_rd_adr = '0;
    tick();
    checks++;
    if (s_acc !== 2'b01) $display("FAIL first_accept: got %b want 01", s_acc);
    else passed++;
    drain("reset");
  endtask

  task automatic test_latency();
    int first = -1;
    lat[0] = 1; lat[1] = 1;
    mem_ready = 1'b1; out_rdy = 2'b01; cl_read = 2'b01;
    cl_rd_adr = {13'h0, 13'h0010};
    tick();
    cl_read = '0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k == 1) begin
        checks++;
        if (s_read !== 2'b01 || s_rd_adr[BITADDR-1:0] !== 13'h0010)
          $display("FAIL lat_read: got read=%b adr=%h want 01/0010", s_read, s_rd_adr[BITADDR-1:0]);
        else passed++;
      end
      if (first < 0 && s_out_vld[0]) first = k;
    end
    checks++;
    if (first !== LAT_EXP) $display("FAIL lat_out_vld: got %0d cycles want %0d", first, LAT_EXP);
    else passed++;
    checks++;
    if (s_err !== 2'b00) $display("FAIL lat_err: got %b want 00", s_err);
    else passed++;
    drain("latency");
  endtask

  task automatic test_backpressure();
    int acc = 0, pops = 0, n = 0;
    bit seen = 1'b0;
    lat[0] = 1;
    out_rdy = 2'b00; cl_read = 2'b01;
    for (int i = 0; i < 5; i++) begin
      cl_rd_adr[BITADDR-1:0] = 13'(16'h0300 + i);
      tick();
      if (s_acc[0]) acc++;
    end
    checks++;
    if (s_cl_rdy[0] !== 1'b0) $display("FAIL bp_rdy_5th: got %b want 0", s_cl_rdy[0]);
    else passed++;
    checks++;
    if (acc != DEPTH) $display("FAIL bp_accepts: got %0d want %0d", acc, DEPTH);
    else passed++;
    cl_read = '0; out_rdy = 2'b01;
    while (pops < DEPTH && n < 20) begin
      tick(); n++;
      if (seen) begin
        checks++;
        if (s_cl_rdy[0] !== 1'b1) $display("FAIL bp_rdy_after_pop: got %b want 1", s_cl_rdy[0]);
        else passed++;
        seen = 1'b0;
      end
      if (s_pop[0]) begin
        if (pops == 0) seen = 1'b1;
        pops++;
      end
    end
    checks++;
    if (pops != DEPTH) $display("FAIL bp_pops: got %0d want %0d", pops, DEPTH);
    else passed++;
    drain("backpressure");
  endtask

  task automatic test_dual_port();
    int a0 = n_acc[0], a1 = n_acc[1], p0 = n_pop[0], p1 = n_pop[1];
    lat[0] = 1; lat[1] = 2;
    out_rdy = 2'b11; cl_read = 2'b11;
    for (int i = 0; i < 16; i++) begin
      cl_rd_adr = {13'(16'h0200 + i), 13'(16'h0100 + i)};
      tick();
    end
    drain("dual");
    checks++;
    if ((n_pop[0] - p0) != (n_acc[0] - a0) || (n_pop[1] - p1) != (n_acc[1] - a1) ||
        (n_acc[0] - a0) == 0 || (n_acc[1] - a1) == 0)
      $display("FAIL dual_counts: got pops %0d/%0d want accepts %0d/%0d",
               n_pop[0] - p0, n_pop[1] - p1, n_acc[0] - a0, n_acc[1] - a1);
    else passed++;
  endtask

  task automatic test_mem_ready();
    int pops = 0, n = 0;
    lat[0] = 3;
    out_rdy = 2'b01; cl_read = 2'b01;
    for (int i = 0; i < 2; i++) begin
      cl_rd_adr[BITADDR-1:0] = 13'(16'h0400 + i);
      tick();
      if (s_pop[0]) pops++;
    end
    mem_ready = 1'b0;
    tick();
    if (s_pop[0]) pops++;
    checks++;
    if (s_cl_rdy[0] !== 1'b0) $display("FAIL mr_rdy: got %b want 0", s_cl_rdy[0]);
    else passed++;
    while (exp_q[0].size() > 0 && n < 15) begin
      tick(); n++;
      if (s_pop[0]) pops++;
    end
    checks++;
    if (pops != 2) $display("FAIL mr_delivered: got %0d want 2", pops);
    else passed++;
    mem_ready = 1'b1;
    drain("mem_ready");
  endtask

  task automatic test_random();
    lat[0] = int'($urandom_range(1, 3)); lat[1] = int'($urandom_range(1, 3));
    for (int i = 0; i < 300; i++) begin
      cl_read   = 2'($urandom_range(0, 3));
      cl_rd_adr = 26'($urandom);
      out_rdy   = {($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 7)};
      mem_ready = ($urandom_range(0, 9) != 0);
      tick();
    end
    drain("random");
    checks++;
    if (err !== 2'b00) $display("FAIL random_err: got %b want 00", err);
    else passed++;
  endtask

  task automatic test_spurious();
    out_rdy = 2'b11; cl_read = '0;
    inj_vld = 2'b10; inj_data = 32'hDEAD_BEEF;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (s_err !== 2'b10 || s_out_vld[1] !== 1'b0)
        $display("FAIL spurious_err: got err=%b vld1=%b want 10/0", s_err, s_out_vld[1]);
      else passed++;
    end
  endtask

  task automatic test_reset_midflight();
    int acc = 0;
    auto_mem = 1'b0;
    out_rdy = 2'b01; cl_read = 2'b01;
    for (int i = 0; i < 3; i++) begin
      cl_rd_adr[BITADDR-1:0] = 13'(16'h0500 + i);
      tick();
      if (s_acc[0]) acc++;
    end
    checks++;
    if (acc != 3) $display("FAIL rmf_accepts: got %0d want 3", acc);
    else passed++;
    cl_read = '0; rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (s_err !== 2'b00) $display("FAIL rmf_err_cleared: got %b want 00", s_err);
    else passed++;
    tick();
    inj_vld = 2'b01; inj_data = 32'h0BAD_F00D;
    tick();
    checks++;
    if (s_out_vld[0] !== 1'b0) $display("FAIL rmf_no_bypass: got %b want 0", s_out_vld[0]);
    else passed++;
    tick();
    checks++;
    if (s_err !== 2'b01 || s_out_vld !== 2'b00)
      $display("FAIL rmf_spurious: got err=%b vld=%b want 01/00", s_err, s_out_vld);
    else passed++;
    checks++;
    if (dut.g_lane[0].crd_q !== 3'd0) $display("FAIL rmf_crd: got %0d want 0", dut.g_lane[0].crd_q);
    else passed++;
    auto_mem = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (s_err !== 2'b00) $display("FAIL final_err_clear: got %b want 00", s_err);
    else passed++;
  endtask

  initial begin
    rst = 1'b1; mem_ready = 1'b0; cl_read = '0; cl_rd_adr = '0;
    rd_vld = '0; rd_dout = '0; out_rdy = '0;
    lat[0] = 1; lat[1] = 1;
    n_acc[0] = 0; n_acc[1] = 0; n_pop[0] = 0; n_pop[1] = 0;
    exp_adr[0] = '0; exp_adr[1] = '0;
    @(negedge clk);
    test_reset();
    test_latency();
    test_backpressure();
    test_dual_port();
    test_mem_ready();
    test_random();
    test_spurious();
    test_reset_midflight();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/algo_2ror1w_rdq.md
ALGO_2ROR1W_RDQ -- requirements
Module: algo_2ror1w_rdq

Interface
REQ-001 Parameters SHALL be:
- WIDTH, 32, data width.
- BITADDR, 13, address width.
- DEPTH, 4, per-port response queue depth.
- BITDEPTH, 2, log2(DEPTH).
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, single clock.
- rst, in, 1, synchronous active-high reset.
- mem_ready, in, 1, ready from the 2ror1w memory top.
- cl_read, in, 2, client read request, one bit per port.
- cl_rd_adr, in, 2*BITADDR, client addresses, port p at [p*BITADDR +: BITADDR].
- cl_rdy, out, 2, request accepted when cl_read[p] & cl_rdy[p].
- read, out, 2, read strobes to the memory.
- rd_adr, out, 2*BITADDR, addresses to the memory.
- rd_vld, in, 2, response valid from the memory.
- rd_dout, in, 2*WIDTH, response data from the memory.
- out_vld, out, 2, queued response valid to the consumer.
- out_dout, out, 2*WIDTH, queued response data.
- out_rdy, in, 2, consumer accept.
- err, out, 2, sticky per-port protocol error.

Function
REQ-003 Ports 0 and 1 SHALL be fully independent identical lanes; all following requirements are per port p.
REQ-004 Credit counter crd (BITDEPTH+1 bits) SHALL equal requests in flight plus entries queued.
REQ-005 cl_rdy[p] SHALL be mem_ready & (crd < DEPTH), combinational.
REQ-006 On accept, read[p] and rd_adr[p] SHALL be registered and presented exactly one cycle later, for one cycle; otherwise read[p]=0 and rd_adr holds its last value.
REQ-007 Counter updates SHALL be: crd +1 on accept, -1 on pop (out_vld & out_rdy), unchanged when both occur in the same cycle.
REQ-008 In-flight counter infl (BITDEPTH+1 bits) SHALL be +1 when read[p] is driven and -1 on rd_vld[p]; simultaneous events leave it unchanged.
REQ-009 On rd_vld[p] with infl>0, rd_dout[p] SHALL be pushed into a DEPTH-entry FIFO with wrapping BITDEPTH-bit pointers and an occupancy count.
REQ-010 rd_vld[p] with infl==0 (spurious), or a push to a full FIFO without a same-cycle pop, SHALL drop the data and set err[p].
REQ-011 Push and pop in the same cycle on a full FIFO SHALL both succeed.
REQ-012 out_vld[p] SHALL be high whenever the FIFO is non-empty; out_dout SHALL be the head entry, stable until popped.
REQ-013 The consumer SHALL see responses in request order, with no loss or duplication while err=0.
REQ-014 Deasserting mem_ready SHALL block new accepts only; queued and in-flight traffic SHALL continue to drain.
REQ-015 Minimum request-to-out_vld latency SHALL be 1 + (memory latency) + 1 cycles (registered FIFO output).

Reset
REQ-016 While rst=1, the following SHALL be cleared: crd, infl, pointers, occupancy, read, rd_adr, out_vld and err; cl_rdy SHALL be 0.
REQ-017 Reset mid-operation SHALL discard all queued and in-flight state; a rd_vld arriving after reset for a pre-reset request SHALL be treated as spurious (REQ-010).
REQ-018 The first accept SHALL be possible in the first cycle after rst falls, if mem_ready=1.

Configuration
REQ-019 Macro ALGO_2ROR1W_RDQ_BYPASS_EN:
- Defined: when the FIFO is empty, out_rdy[p]=1 and rd_vld[p] is valid, rd_dout SHALL pass combinationally to out_dout with out_vld=1 in the same cycle, without a push; the credit and in-flight counters update as for push+pop. Minimum latency drops by 1.
- Undefined: all responses SHALL go through the FIFO (REQ-015).

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Reset, then mem_ready=1, cl_read=2'b01 at adr 0x0010, memory latency 1 -> read[0] one cycle later with adr 0x0010; out_vld[0] 3 cycles after accept (2 with BYPASS); err=0.
- out_rdy[0]=0 with 5 back-to-back requests -> 4 accepted, cl_rdy[0]=0 on the 5th; set out_rdy=1 -> 4 pops in order, cl_rdy[0]=1 again after the first pop.
- Both ports request every cycle with different addresses, out_rdy=1 -> each port's data returns in its own issue order, no cross-port mixing.
- mem_ready=0 while 2 requests are in flight -> cl_rdy=0; both responses are still delivered to the consumer.
- rd_vld[1] pulsed with no outstanding request -> err[1]=1 and stays 1 until reset; out_vld[1] stays 0.
- rst asserted with 3 in flight, rd_vld returns 2 cycles after rst falls -> err set, out_vld=0, crd=0.
